switch_debouncer: RTL

- Front-end conditioning stage for the slide switches on the board.
- Sits directly upstream of the 3-bit switch PIO: sw_stable drives that PIO's in_port.
- Synchronises each raw asynchronous switch line into clk, rejects contact bounce with a per-bit stability counter, and presents a clean level plus one-cycle edge pulses.
- The edge pulses (rise, fall, any-change) are available for future interrupt/edge-capture use.

---
 rtl/switch_debouncer.sv | 92 +++++++++
 1 files changed

// File: rtl/switch_debouncer.sv
// Switch conditioning: 2-flop synchroniser, per-bit stability counter,
// registered debounced level and one-cycle rise/fall/changed pulses.
module switch_debouncer #(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             changed
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;
    logic             changed_q;
    logic             changed_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Synchroniser flops: s1 may go metastable, only s2 is consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= sw_raw;
            s2_q <= s1_q;
        end
    end

    // Per-bit debounce: PENDING is implied by s2 differing from the stable level.
    always_comb begin
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = s2_q[i];
                    rise_d[i]   = s2_q[i];
                    fall_d[i]   = ~s2_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
        changed_d = |(rise_d | fall_d);
    end

    // Debounce state and registered pulse outputs; reset overrides any commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q  <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q  <= stable_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_stable  = stable_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign changed    = changed_q;

endmodule
